// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add unsigned multiplier with start/busy/done controller.
// Defining MUL_EARLY_TERM_EN lets an operation finish once no set multiplier bits remain.
module mul_seq_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [1:0]           state,
  output logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_EXEC = 2'd1,
    S_IDLE = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [CW-1:0] LP_CNT_MAX = CW'(WIDTH);

  state_t               r_state, w_state_nxt;
  logic [2*WIDTH-1:0]   r_p, w_p_nxt, w_p_step;
  logic [WIDTH-1:0]     r_m, w_m_nxt;
  logic [CW-1:0]        r_count, w_cnt_nxt, w_cnt_step;
  logic [WIDTH:0]       w_sum;
  logic                 w_load_prod;
  logic [2*WIDTH-1:0]   r_product;

  // In a step state P[0] is the bit being processed, so it equals "state is EXEC".
  assign w_sum      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){r_p[0]}} & {1'b0, r_m});
  assign w_p_step   = {w_sum, r_p[WIDTH-1:1]};
  assign w_cnt_step = r_count + CW'(1);

`ifdef MUL_EARLY_TERM_EN
  logic [CW-1:0]      w_rem;
  logic [2*WIDTH-1:0] w_rem_mask;

  // Low w_rem bits of the shifted P are the multiplier bits not yet processed.
  assign w_rem      = LP_CNT_MAX - w_cnt_step;
  assign w_rem_mask = ~({(2*WIDTH){1'b1}} << w_rem);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_m_nxt     = r_m;
    w_cnt_nxt   = r_count;
    w_load_prod = 1'b0;
    case (r_state)
      S_INIT: begin
        if (start) begin
          w_p_nxt     = {{WIDTH{1'b0}}, multiplier};
          w_m_nxt     = multiplicand;
          w_cnt_nxt   = '0;
          w_state_nxt = multiplier[0] ? S_EXEC : S_IDLE;
`ifdef MUL_EARLY_TERM_EN
          if (multiplier == '0) begin
            w_cnt_nxt   = LP_CNT_MAX;
            w_state_nxt = S_HALT;
            w_load_prod = 1'b1;
          end
`endif
        end
      end
      S_EXEC, S_IDLE: begin
        w_p_nxt   = w_p_step;
        w_cnt_nxt = w_cnt_step;
        if (w_cnt_step == LP_CNT_MAX) begin
          w_state_nxt = S_HALT;
          w_load_prod = 1'b1;
        end
`ifdef MUL_EARLY_TERM_EN
        else if ((w_p_step & w_rem_mask) == '0) begin
          w_p_nxt     = w_p_step >> w_rem;
          w_cnt_nxt   = LP_CNT_MAX;
          w_state_nxt = S_HALT;
          w_load_prod = 1'b1;
        end
`endif
        else begin
          w_state_nxt = w_p_step[0] ? S_EXEC : S_IDLE;
        end
      end
      S_HALT: begin
        w_state_nxt = S_INIT;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state   <= S_INIT;
      r_p       <= '0;
      r_m       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_m     <= w_m_nxt;
      r_count <= w_cnt_nxt;
      if (w_load_prod) r_product <= w_p_nxt;
    end
  end

  assign state   = r_state;
  assign count   = r_count;
  assign busy    = (r_state == S_EXEC) || (r_state == S_IDLE);
  assign done    = (r_state == S_HALT);
  assign product = r_product;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl at WIDTH 8, 16 and 13 against an A*B reference model.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
  int          sel = 0;
  int          checks = 0;
  int          failures = 0;

  logic        st0, st1, st2;
  logic [1:0]  state8, state16, state13;
  logic [3:0]  cnt8, cnt13;
  logic [4:0]  cnt16;
  logic        busy8, busy16, busy13, done8, done16, done13;
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic [25:0] prod13;

  logic [1:0]  m_state;
  logic [31:0] m_cnt;
  logic        m_busy, m_done;
  logic [63:0] m_prod;

  always #5 clk = ~clk;

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);

  mul_seq_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .areset_n(rst_n), .start(st0),
    .multiplicand(opa[7:0]), .multiplier(opb[7:0]),
    .state(state8), .count(cnt8), .busy(busy8), .done(done8), .product(prod8)
  );

  mul_seq_ctrl #(.WIDTH(16)) u_w16 (
    .clk(clk), .areset_n(rst_n), .start(st1),
    .multiplicand(opa), .multiplier(opb),
    .state(state16), .count(cnt16), .busy(busy16), .done(done16), .product(prod16)
  );

  mul_seq_ctrl #(.WIDTH(13)) u_w13 (
    .clk(clk), .areset_n(rst_n), .start(st2),
    .multiplicand(opa[12:0]), .multiplier(opb[12:0]),
    .state(state13), .count(cnt13), .busy(busy13), .done(done13), .product(prod13)
  );

  always_comb begin
    m_state = state8;
    m_cnt   = 32'(cnt8);
    m_busy  = busy8;
    m_done  = done8;
    m_prod  = 64'(prod8);
    case (sel)
      1: begin
        m_state = state16; m_cnt = 32'(cnt16); m_busy = busy16;
        m_done  = done16;  m_prod = 64'(prod16);
      end
      2: begin
        m_state = state13; m_cnt = 32'(cnt13); m_busy = busy13;
        m_done  = done13;  m_prod = 64'(prod13);
      end
      default: ;
    endcase
  end

  function automatic int width_of(input int s);
    return (s == 1) ? 16 : (s == 2) ? 13 : 8;
  endfunction

  function automatic int msb_idx(input logic [15:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference: product = A*B; step c adds iff multiplier bit c-1 is set; done cycle from latency rule.
  task automatic do_op(input int s, input logic [15:0] a, input logic [15:0] b, input bit noise);
    int          w, lat, dcyc;
    logic [15:0] mask, am, bm;
    logic [63:0] exp_p;
    logic [1:0]  exp_st;
    bit          seen;
    w     = width_of(s);
    mask  = 16'((32'd1 << w) - 1);
    am    = a & mask;
    bm    = b & mask;
    exp_p = 64'(am) * 64'(bm);
`ifdef MUL_EARLY_TERM_EN
    lat = (bm == 16'd0) ? 1 : msb_idx(bm) + 2;
`else
    lat = w + 1;
`endif
    sel = s; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0; dcyc = 0;
    for (int c = 1; c <= w + 3; c++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        seen = 1; dcyc = c;
        break;
      end
      exp_st = ((c - 1) < 16 && bm[(c-1) % 16]) ? 2'd1 : 2'd2;
      checks++;
      if (m_state !== exp_st || m_busy !== 1'b1 || m_cnt !== 32'(c - 1)) begin
        failures++;
        $display("FAIL step W=%0d A=%0d B=%0d cyc=%0d: state=%0d busy=%0d count=%0d, expected state=%0d busy=1 count=%0d",
                 w, am, bm, c, m_state, m_busy, m_cnt, exp_st, c - 1);
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        opa = 16'($urandom); opb = 16'($urandom);
      end
    end
    checks++;
    if (dcyc !== lat) begin
      failures++;
      $display("FAIL latency W=%0d A=%0d B=%0d: done cycle=%0d (0=none), expected %0d", w, am, bm, dcyc, lat);
    end
    if (seen) begin
      checks++;
      if (m_prod !== exp_p || m_cnt !== 32'(w) || m_busy !== 1'b0 || m_state !== 2'd3) begin
        failures++;
        $display("FAIL halt W=%0d A=%0d B=%0d: product=%0d count=%0d busy=%0d state=%0d, expected product=%0d count=%0d busy=0 state=3",
                 w, am, bm, m_prod, m_cnt, m_busy, m_state, exp_p, w);
      end
      if (noise) begin
        start = 1'b1; opa = 16'($urandom); opb = 16'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (m_state !== 2'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_prod !== exp_p) begin
        failures++;
        $display("FAIL init_after W=%0d A=%0d B=%0d: state=%0d busy=%0d done=%0d product=%0d, expected state=0 busy=0 done=0 product=%0d",
                 w, am, bm, m_state, m_busy, m_done, m_prod, exp_p);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if (m_state !== 2'd0 || m_cnt !== 32'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_prod !== 64'd0) begin
        failures++;
        $display("FAIL reset sel=%0d: state=%0d count=%0d busy=%0d done=%0d product=%0d, expected all 0",
                 s, m_state, m_cnt, m_busy, m_done, m_prod);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel = 0;
  endtask

  task automatic test_directed();
    do_op(0, 16'd13, 16'd11, 0);
    do_op(0, 16'd255, 16'd255, 0);
    do_op(1, 16'd0, 16'hFFFF, 0);
    do_op(1, 16'hFFFF, 16'd0, 0);
    do_op(0, 16'd3, 16'd2, 0);
    do_op(2, 16'h1FFF, 16'h1FFF, 0);
  endtask

  task automatic test_mid_reset();
    logic [15:0] b;
    logic [1:0]  exp_st;
`ifdef MUL_EARLY_TERM_EN
    b = 16'd131;
`else
    b = 16'd3;
`endif
    sel = 0; opa = 16'd200; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c < 5) begin
        exp_st = b[c-1] ? 2'd1 : 2'd2;
        checks++;
        if (m_state !== exp_st || m_busy !== 1'b1 || m_done !== 1'b0 || m_cnt !== 32'(c - 1)) begin
          failures++;
          $display("FAIL midop cyc=%0d: state=%0d busy=%0d done=%0d count=%0d, expected state=%0d busy=1 done=0 count=%0d",
                   c, m_state, m_busy, m_done, m_cnt, exp_st, c - 1);
        end
      end
      if (c >= 2) begin
        start = 1'b1; opa = 16'($urandom); opb = 16'($urandom);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (m_state !== 2'd0 || m_prod !== 64'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_cnt !== 32'd0) begin
      failures++;
      $display("FAIL midop_reset: state=%0d product=%0d busy=%0d done=%0d count=%0d, expected all 0",
               m_state, m_prod, m_busy, m_done, m_cnt);
    end
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (m_done !== 1'b0 || m_state !== 2'd0) begin
        failures++;
        $display("FAIL held_reset: done=%0d state=%0d, expected done=0 state=0", m_done, m_state);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_state !== 2'd0 || m_prod !== 64'd0 || m_done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: state=%0d product=%0d done=%0d, expected 0 0 0", m_state, m_prod, m_done);
    end
    do_op(0, 16'd7, 16'd6, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1000; i++) do_op(0, 16'($urandom), 16'($urandom), 1);
    for (int i = 0; i < 1000; i++) do_op(2, 16'($urandom), 16'($urandom), 1);
    for (int i = 0; i < 100; i++)  do_op(1, 16'($urandom), 16'($urandom), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
